// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: reads upper byte at pc, lower at pc+1,
// pulsing the IR load strobes, with a per-byte ack timeout and sticky error flag.
module fetch_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pc_load,
  input  logic [7:0] pc_load_val,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       mem_req,
  output logic [7:0] pc_out,
  output logic [7:0] mdr_data,
  output logic       load_iru,
  output logic       load_irl,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, REQ_HI, LOAD_HI, REQ_LO, LOAD_LO, DONE} state_t;

  // Last wait cycle index; an ack on this cycle still counts as success.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= 8'h00;
      mdr_data <= 8'h00;
      wait_cnt <= 8'h00;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end else if (start) begin
            error    <= 1'b0;
            wait_cnt <= 8'h00;
            state    <= REQ_HI;
          end
        end
        REQ_HI, REQ_LO: begin
          if (mem_ack) begin
            mdr_data <= mem_rdata;
            pc       <= pc + 8'd1;
            wait_cnt <= 8'h00;
            state    <= (state == REQ_HI) ? LOAD_HI : LOAD_LO;
          end else if (wait_cnt == WAIT_LAST) begin
            error    <= 1'b1;
            wait_cnt <= 8'h00;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LOAD_HI: state <= REQ_LO;
        LOAD_LO: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  assign mem_req  = (state == REQ_HI) || (state == REQ_LO);
  assign load_iru = (state == LOAD_HI);
  assign load_irl = (state == LOAD_LO);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);
  assign pc_out   = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level fetch model.
module tb_fetch_sequencer;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset, start, pc_load, mem_ack;
  logic [7:0] pc_load_val, mem_rdata;
  logic       mem_req, load_iru, load_irl, busy, done, error;
  logic [7:0] pc_out, mdr_data;

  logic [7:0] mem [256];
  logic       rd_force;
  logic [7:0] rd_val;
  logic [7:0] exp_pc, exp_mdr;
  int total = 0, bad = 0;

  fetch_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .pc_out(pc_out), .mdr_data(mdr_data),
    .load_iru(load_iru), .load_irl(load_irl), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = rd_force ? rd_val : mem[pc_out];

  // One fetch; dh/dl = idle cycles before ack per byte (>= TO means timeout).
  task automatic run_fetch(input string nm, input int dh, input int dl, input bit noise);
    int iru_c = -1, irl_c = -1, done_c = -1, iru_n = 0, irl_n = 0, done_n = 0;
    int reqs = 0, ov = 0, w = 0, d, e_iru, e_irl, e_done, e_reqs;
    logic [7:0] iru_m = 8'h00, irl_m = 8'h00, e_pc, b_hi, b_lo, p1;
    bit e_err, busy1 = 0, err1 = 1, idle_seen = 0;
    p1 = exp_pc + 8'd1;
    b_hi = mem[exp_pc];
    b_lo = mem[p1];
    if (dh >= TO) begin
      e_iru = -1; e_irl = -1; e_done = -1; e_reqs = TO; e_err = 1; e_pc = exp_pc;
    end else if (dl >= TO) begin
      e_iru = dh + 2; e_irl = -1; e_done = -1; e_reqs = dh + 1 + TO; e_err = 1;
      e_pc = p1; exp_mdr = b_hi;
    end else begin
      e_iru = dh + 2; e_irl = dh + dl + 4; e_done = dh + dl + 5; e_reqs = dh + dl + 2;
      e_err = 0; e_pc = exp_pc + 8'd2; exp_mdr = b_lo;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (cyc == 1) begin busy1 = busy; err1 = error; end
      if (!busy) begin idle_seen = 1; break; end
      if (load_iru) begin iru_n++; if (iru_c < 0) begin iru_c = cyc; iru_m = mdr_data; end end
      if (load_irl) begin irl_n++; if (irl_c < 0) begin irl_c = cyc; irl_m = mdr_data; end end
      if (done) begin done_n++; if (done_c < 0) done_c = cyc; end
      if (load_iru && load_irl) ov++;
      if (mem_req) reqs++;
      if (mem_req) begin
        d = (iru_n > 0) ? dl : dh;
        mem_ack = (w == d);
        w = mem_ack ? 0 : w + 1;
      end else begin
        w = 0;
        mem_ack = noise ? 1'($urandom) : 1'b0;
      end
      if (noise) begin pc_load = 1'($urandom); pc_load_val = 8'($urandom); end
      @(negedge clk);
    end
    pc_load = 1'b0; mem_ack = 1'b0;
    total++; if (!idle_seen) begin bad++; $display("FAIL %s idle_bound: never returned to idle", nm); end
    total++; if (busy1 !== 1'b1 || err1 !== 1'b0) begin bad++; $display("FAIL %s first_cycle: busy=%b error=%b want 1 0", nm, busy1, err1); end
    total++; if (iru_c !== e_iru) begin bad++; $display("FAIL %s iru_cycle: got %0d want %0d", nm, iru_c, e_iru); end
    total++; if (irl_c !== e_irl) begin bad++; $display("FAIL %s irl_cycle: got %0d want %0d", nm, irl_c, e_irl); end
    total++; if (done_c !== e_done) begin bad++; $display("FAIL %s done_cycle: got %0d want %0d", nm, done_c, e_done); end
    if (e_iru >= 0) begin
      total++; if (iru_m !== b_hi) begin bad++; $display("FAIL %s iru_mdr: got %h want %h", nm, iru_m, b_hi); end
    end
    if (e_irl >= 0) begin
      total++; if (irl_m !== b_lo) begin bad++; $display("FAIL %s irl_mdr: got %h want %h", nm, irl_m, b_lo); end
    end
    total++; if (iru_n !== (e_iru >= 0 ? 1 : 0) || irl_n !== (e_irl >= 0 ? 1 : 0) || done_n !== (e_done >= 0 ? 1 : 0))
      begin bad++; $display("FAIL %s pulse_count: iru=%0d irl=%0d done=%0d", nm, iru_n, irl_n, done_n); end
    total++; if (ov !== 0) begin bad++; $display("FAIL %s load_overlap: got %0d want 0", nm, ov); end
    total++; if (reqs !== e_reqs) begin bad++; $display("FAIL %s req_cycles: got %0d want %0d", nm, reqs, e_reqs); end
    total++; if (error !== e_err) begin bad++; $display("FAIL %s error: got %b want %b", nm, error, e_err); end
    total++; if (pc_out !== e_pc) begin bad++; $display("FAIL %s pc: got %h want %h", nm, pc_out, e_pc); end
    total++; if (mdr_data !== exp_mdr) begin bad++; $display("FAIL %s mdr_final: got %h want %h", nm, mdr_data, exp_mdr); end
    exp_pc = e_pc;
  endtask

  task automatic do_pc_load(input string nm, input logic [7:0] val, input bit with_start);
    @(negedge clk); pc_load = 1'b1; start = with_start; pc_load_val = val;
    @(negedge clk); pc_load = 1'b0; start = 1'b0;
    exp_pc = val;
    total++; if (pc_out !== val || busy !== 1'b0) begin bad++; $display("FAIL %s pc_load: pc=%h busy=%b want %h 0", nm, pc_out, busy, val); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after_load: got %b want 0", nm, busy); end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({mem_req, load_iru, load_irl, busy, done, error} !== 6'b0 || pc_out !== 8'h00 || mdr_data !== 8'h00)
      begin bad++; $display("FAIL reset_state: outs=%b pc=%h mdr=%h want zeros", {mem_req, load_iru, load_irl, busy, done, error}, pc_out, mdr_data); end
    @(negedge clk); reset = 1'b1;
    exp_pc = 8'h00; exp_mdr = 8'h00;
  endtask

  task automatic test_basic;
    mem[8'h00] = 8'hA5; mem[8'h01] = 8'h3C;
    run_fetch("basic", 0, 0, 0);
  endtask

  task automatic test_wrap;
    mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
    do_pc_load("wrap", 8'hFF, 0);
    run_fetch("wrap", 0, 0, 0);
  endtask

  task automatic test_timeout;
    run_fetch("timeout_hi", 100, 0, 0);
    run_fetch("clear_err", 0, 0, 0);
    run_fetch("timeout_lo", 2, 100, 0);
    run_fetch("ack_last", TO - 1, TO - 1, 0);
    run_fetch("to_exact", TO, 0, 0);
  endtask

  task automatic test_delay;
    run_fetch("delay3", 3, 3, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || load_iru !== 1'b0) begin bad++; $display("FAIL rst_mid_in_req_lo: mem_req=%b want 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mem_req, load_iru, load_irl, busy, done, error} !== 6'b0 || pc_out !== 8'h00 || mdr_data !== 8'h00)
      begin bad++; $display("FAIL rst_mid_clear: outs=%b pc=%h mdr=%h want zeros", {mem_req, load_iru, load_irl, busy, done, error}, pc_out, mdr_data); end
    @(negedge clk); reset = 1'b1; mem_ack = 1'b1;
    exp_pc = 8'h00; exp_mdr = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (load_irl !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_release: irl=%b busy=%b want 0 0", load_irl, busy); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_load_priority;
    do_pc_load("prio", 8'h40, 1);
    @(negedge clk); rd_force = 1'b1; rd_val = ~exp_mdr; mem_ack = 1'b1;
    @(negedge clk); rd_force = 1'b0; mem_ack = 1'b0;
    total++; if (mdr_data !== exp_mdr || busy !== 1'b0) begin bad++; $display("FAIL stray_ack: mdr=%h busy=%b want %h 0", mdr_data, busy, exp_mdr); end
    @(negedge clk); pc_load_val = 8'h77; // pc_load low: pc must hold
    total++; if (pc_out !== 8'h40) begin bad++; $display("FAIL prio_hold: pc=%h want 40", pc_out); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) do_pc_load("rnd_load", 8'($urandom), 0);
      run_fetch("random", $urandom_range(0, 17), $urandom_range(0, 17), 1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;
    mem_ack = 1'b0; rd_force = 1'b0; rd_val = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset;
    test_basic;
    test_wrap;
    test_timeout;
    test_delay;
    test_reset_mid;
    test_load_priority;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter SHALL be: TIMEOUT, 15, max wait cycles for mem_ack per byte request (range 1..255).
REQ-002 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port start  input  1  request one 16-bit instruction fetch, sampled in IDLE only.
REQ-005 Port pc_load  input  1  load program counter from pc_load_val, honoured in IDLE only.
REQ-006 Port pc_load_val  input  8  new PC value.
REQ-007 Port mem_ack  input  1  memory has valid mem_rdata this cycle.
REQ-008 Port mem_rdata  input  8  memory read byte.
REQ-009 Port mem_req  output  1  memory read request, held until ack or timeout.
REQ-010 Port pc_out  output  8  current PC, used as memory address.
REQ-011 Port mdr_data  output  8  captured byte, feeds the instruction register's mdr_data input.
REQ-012 Port load_iru  output  1  one-cycle pulse, load upper IR byte from mdr_data.
REQ-013 Port load_irl  output  1  one-cycle pulse, load lower IR byte from mdr_data.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port done  output  1  one-cycle pulse, fetch completed.
REQ-016 Port error  output  1  sticky timeout flag, cleared by next accepted start or reset.

Function
REQ-017 FSM states SHALL be IDLE, REQ_HI, LOAD_HI, REQ_LO, LOAD_LO, DONE; all outputs registered or decoded from state only.
REQ-018 IDLE: pc_load=1 -> pc <= pc_load_val, stay IDLE; else start=1 -> error <= 0, wait counter <= 0, go REQ_HI.
REQ-019 pc_load and start both high in IDLE -> load wins, start ignored that cycle.
REQ-020 pc_load outside IDLE SHALL be ignored.
REQ-021 REQ_HI/REQ_LO: mem_req=1, pc_out=pc; mem_ack=1 -> mdr_data <= mem_rdata, pc <= pc+1, counter <= 0, go LOAD_HI/LOAD_LO respectively.
REQ-022 REQ_x without ack: counter increments each cycle; counter reaching TIMEOUT with no ack -> error <= 1, mem_req drops, go IDLE, pc unchanged for that byte, no load pulse, no done.
REQ-023 Ack in the same cycle counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-024 LOAD_HI: load_iru=1 exactly one cycle, mdr_data stable, go REQ_LO; LOAD_LO: load_irl=1 one cycle, go DONE.
REQ-025 DONE: done=1 one cycle, go IDLE; upper byte always fetched first from pc, lower from pc+1.
REQ-026 mem_ack outside REQ_HI/REQ_LO SHALL be ignored; mdr_data unchanged.
REQ-027 PC arithmetic 8-bit modulo: 0xFF+1 = 0x00, no flag.
REQ-028 Minimum latency start -> done pulse with mem_ack tied high: 5 cycles (REQ_HI, LOAD_HI, REQ_LO, LOAD_LO, DONE).
REQ-029 load_iru and load_irl SHALL never be high in the same cycle.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, pc=0x00, mdr_data=0x00, counter=0, and mem_req, load_iru, load_irl, busy, done, error all 0.
REQ-031 Reset mid-fetch SHALL abort with no pending load pulse on release; operation resumes on rising edges after reset=1.

Verification
REQ-032 Reset, mem_ack=1, mem {0x00:0xA5, 0x01:0x3C}, pulse start -> load_iru with mdr=0xA5, then load_irl with mdr=0x3C, done 5 cycles after start, pc_out=0x02.
REQ-033 pc_load_val=0xFF + pc_load, then start, mem {0xFF:0x12, 0x00:0x34} -> bytes 0x12 then 0x34, final pc=0x01 (wrap).
REQ-034 TIMEOUT=15, mem_ack held 0 after start -> mem_req high 15 cycles, error=1, busy=0, no load pulses, pc unchanged; next start clears error.
REQ-035 mem_ack delayed 3 cycles on each byte -> done 11 cycles after start, error=0.
REQ-036 reset=0 asserted while in REQ_LO -> all outputs 0 immediately, pc=0x00, no load_irl after release.
REQ-037 start and pc_load high together in IDLE with pc_load_val=0x40 -> pc=0x40, busy stays 0; stray mem_ack in IDLE leaves mdr_data unchanged.
